// File: rtl/mem_port_arbiter_if.sv
// Bundles the pipeline-side request/response signals and the memory-side bus of
// mem_port_arbiter. Signal names are seen from the arbiter: _i enters it, _o leaves it.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   // Pipeline side
   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic              d_req_i;
   logic              d_we_i;
   logic [ADDR_W-1:0] d_addr_i;
   logic [DATA_W-1:0] d_wdata_i;
   logic              if_done_o;
   logic              d_done_o;
   logic [DATA_W-1:0] rdata_o;
   logic              stall_if_o;
   logic              stall_mem_o;
   // Memory side
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic              mem_ready_i;
   logic              mem_rvalid_i;
   logic [DATA_W-1:0] mem_rdata_i;

   // Arbiter view
   modport slave (
      input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
      input  mem_ready_i, mem_rvalid_i, mem_rdata_i,
      output if_done_o, d_done_o, rdata_o, stall_if_o, stall_mem_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
   );

   // Environment view (pipeline stages plus memory)
   modport master (
      output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
      output mem_ready_i, mem_rvalid_i, mem_rdata_i,
      input  if_done_o, d_done_o, rdata_o, stall_if_o, stall_mem_o,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the MEM-stage data
// access. Data wins ties, but after MAX_D_STREAK consecutive data grants with a
// waiting fetch, the fetch is granted once.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   mem_port_arbiter_if.slave   bus
);

   localparam int unsigned         StreakW   = $clog2(MAX_D_STREAK + 1);
   localparam logic [StreakW-1:0]  StreakMax = StreakW'(MAX_D_STREAK);

   typedef enum logic [1:0] {StIdle, StAddr, StResp, StDone} state_e;

   state_e              state_q, state_d;
   logic                own_data_q, own_data_d;   // 0 = fetch owns the access, 1 = data
   logic [StreakW-1:0]  streak_q, streak_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                grant_if;

   // State and access latches
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         own_data_q <= 1'b0;
         streak_q   <= '0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         own_data_q <= own_data_d;
         streak_q   <= streak_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
      end
   end

   // Grant decision, access sequencing and read-data capture
   always_comb begin
      state_d    = state_q;
      own_data_d = own_data_q;
      streak_d   = streak_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      grant_if   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.if_req_i || bus.d_req_i) begin
               grant_if   = bus.if_req_i && (!bus.d_req_i || (streak_q == StreakMax));
               own_data_d = !grant_if;
               state_d    = StAddr;
               if (grant_if) begin
                  addr_d   = bus.if_addr_i;
                  we_d     = 1'b0;
                  wdata_d  = '0;
                  streak_d = '0;
               end else begin
                  addr_d  = bus.d_addr_i;
                  we_d    = bus.d_we_i;
                  wdata_d = bus.d_wdata_i;
                  // Only count data grants that made a fetch wait
                  if (!bus.if_req_i) begin
                     streak_d = '0;
                  end else if (streak_q != StreakMax) begin
                     streak_d = streak_q + 1'b1;
                  end
               end
            end
         end
         StAddr: begin
            if (bus.mem_ready_i) begin
               state_d = we_q ? StDone : StResp;
            end
         end
         StResp: begin
            if (bus.mem_rvalid_i) begin
               rdata_d = bus.mem_rdata_i;
               state_d = StDone;
            end
         end
         StDone: begin
            // No grant here; the next decision is made in the following idle cycle
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.mem_req_o   = (state_q == StAddr);
   assign bus.mem_we_o    = we_q && (state_q == StAddr);
   assign bus.mem_addr_o  = addr_q;
   assign bus.mem_wdata_o = wdata_q;
   assign bus.rdata_o     = rdata_q;
   assign bus.if_done_o   = (state_q == StDone) && !own_data_q;
   assign bus.d_done_o    = (state_q == StDone) && own_data_q;
   // Stalls depend only on requests and registered state, never on the memory inputs
   assign bus.stall_if_o  = bus.if_req_i && !bus.if_done_o;
   assign bus.stall_mem_o = bus.d_req_i && !bus.d_done_o;

endmodule
